// File: rtl/bram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_arbiter_pkg
// Purpose  : Shared definitions for the BRAM port-B arbiter slice: FSM state
//            encoding, requester IDs and default bus widths.
// Options  : BRAM_ARB_FIXED_PRIO_EN (used in rr_picker2, not here)
// Revision : 1.0 - initial release
// ============================================================================
package bram_port_arbiter_pkg;

  localparam int DEFAULT_ADDR_W = 16;
  localparam int DEFAULT_DATA_W = 16;

  // Requester identifiers; the owner register is one bit wide.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

endpackage : bram_port_arbiter_pkg
`default_nettype wire

// File: rtl/bram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_arbiter_if
// Purpose  : Bundles both requester handshakes, the shared read data, the
//            BRAM port-B pins and the busy flag.
// Ports    : req/we/addr/wdata per requester (in), gnt/done per requester
//            (out), rdata, busy, bram_addr/bram_din/bram_we (out), bram_q (in)
// Modports : slave  - the arbiter
//            master - the surrounding system (requesters + BRAM)
// Revision : 1.0 - initial release
// ============================================================================
interface bram_port_arbiter_if
  import bram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              done0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              done1;

  logic [DATA_W-1:0] rdata;
  logic              busy;

  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              bram_we;
  logic [DATA_W-1:0] bram_q;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  bram_q,
    output gnt0, done0, gnt1, done1,
    output rdata, busy,
    output bram_addr, bram_din, bram_we
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output bram_q,
    input  gnt0, done0, gnt1, done1,
    input  rdata, busy,
    input  bram_addr, bram_din, bram_we
  );

endinterface : bram_port_arbiter_if
`default_nettype wire

// File: rtl/bram_port_arbiter_rr_picker2.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker2
// Purpose  : Two-way winner selection. Combinational pick, registered
//            priority pointer that moves to the non-winner on every grant.
// Options  : BRAM_ARB_FIXED_PRIO_EN - requester 0 always wins on contention,
//            no pointer and no clock/reset ports.
// Ports    : i_clk, i_rst (round-robin build only), i_en (arbitration slot),
//            i_req0, i_req1, o_valid (a grant happens), o_winner (REQ0/REQ1)
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker2
  import bram_port_arbiter_pkg::*;
(
`ifndef BRAM_ARB_FIXED_PRIO_EN
  input  wire logic i_clk,
  input  wire logic i_rst,
`endif
  input  wire logic i_en,
  input  wire logic i_req0,
  input  wire logic i_req1,
  output logic      o_valid,
  output logic      o_winner
);

  logic w_contend;

  assign w_contend = i_req0 & i_req1;
  assign o_valid   = i_en & (i_req0 | i_req1);

`ifdef BRAM_ARB_FIXED_PRIO_EN

  assign o_winner = w_contend ? REQ0 : (i_req1 ? REQ1 : REQ0);

`else

  // Pointer names the requester that wins the next contended slot.
  logic r_ptr;

  assign o_winner = w_contend ? r_ptr : (i_req1 ? REQ1 : REQ0);

  // Any grant, contended or not, hands priority to the other side.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= REQ0;
    end else if (o_valid) begin
      r_ptr <= ~o_winner;
    end
  end

`endif

endmodule : rr_picker2
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_arbiter
// Purpose  : Shares BRAM port B between two requesters, one transaction at a
//            time. Grant +1 cycle, write done +2, read done +3 from the edge
//            the request is sampled in IDLE.
// Options  : BRAM_ARB_FIXED_PRIO_EN - fixed priority to requester 0
//            (selected inside rr_picker2; timing is unchanged).
// Ports    : clk, rst (async, active-high), bus (bram_port_arbiter_if.slave)
// Revision : 1.0 - initial release
// ============================================================================
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input wire logic            clk,
  input wire logic            rst,
  bram_port_arbiter_if.slave  bus
);

  state_t            r_state;
  state_t            w_next;
  logic              r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_done0;
  logic              r_done1;
  logic [DATA_W-1:0] r_rdata;

  logic              w_idle;
  logic              w_grant;
  logic              w_winner;
  logic              w_finish;

  assign w_idle = (r_state == IDLE);

  rr_picker2 u_picker (
`ifndef BRAM_ARB_FIXED_PRIO_EN
    .i_clk    (clk),
    .i_rst    (rst),
`endif
    .i_en     (w_idle),
    .i_req0   (bus.req0),
    .i_req1   (bus.req1),
    .o_valid  (w_grant),
    .o_winner (w_winner)
  );

  // Next state and the "transaction finishes at this edge" strobe.
  always_comb begin
    w_next   = r_state;
    w_finish = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_next = ACCESS;
        end
      end
      ACCESS: begin
        if (r_we) begin
          w_next   = IDLE;
          w_finish = 1'b1;
        end else begin
          w_next = CAPTURE;
        end
      end
      CAPTURE: begin
        w_next   = IDLE;
        w_finish = 1'b1;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= REQ0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_gnt0  <= w_grant & (w_winner == REQ0);
      r_gnt1  <= w_grant & (w_winner == REQ1);
      r_done0 <= w_finish & (r_owner == REQ0);
      r_done1 <= w_finish & (r_owner == REQ1);
      if (w_grant) begin
        r_owner <= w_winner;
        r_addr  <= (w_winner == REQ1) ? bus.addr1  : bus.addr0;
        r_wdata <= (w_winner == REQ1) ? bus.wdata1 : bus.wdata0;
        r_we    <= (w_winner == REQ1) ? bus.we1    : bus.we0;
      end
      // bram_q reflects the address driven during ACCESS.
      if (r_state == CAPTURE) begin
        r_rdata <= bus.bram_q;
      end
    end
  end

  // Address/data registers only change on a grant edge, so they naturally
  // hold their last values outside ACCESS. The write strobe is decoded from
  // the state register so an async reset kills it immediately.
  assign bus.bram_addr = r_addr;
  assign bus.bram_din  = r_wdata;
  assign bus.bram_we   = (r_state == ACCESS) & r_we;

  assign bus.gnt0  = r_gnt0;
  assign bus.gnt1  = r_gnt1;
  assign bus.done0 = r_done0;
  assign bus.done1 = r_done1;
  assign bus.rdata = r_rdata;
  assign bus.busy  = ~w_idle;

endmodule : bram_port_arbiter
`default_nettype wire
